vec_mem_sequencer: RTL and testbench

- Multi-cycle sequencer for the vector VLD/VST instructions.
- The ALU produces only the 16-bit effective address. This block moves a full vector (LANES x LANE_W bits) to or from the 16-bit-wide data memory, one lane per accepted beat.
- Sits between the execute stage (ALU address result, vector register read data) and data memory. It stalls the pipeline while busy and returns the assembled vector for register writeback.

---
 rtl/vec_pkg.sv | 22 ++
 rtl/vec_lane_buffer.sv | 26 ++
 rtl/vec_mem_sequencer.sv | 128 ++++++++++++
 tb/tb_vec_mem_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: lane geometry, sequencer states and lane slicing.
package vec_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned VEC_W  = LANES * LANE_W;
    localparam int unsigned IDX_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Lane idx occupies vec[idx*LANE_W +: LANE_W].
    function automatic logic [LANE_W-1:0] lane_slice(input logic [VEC_W-1:0] vec,
                                                     input logic [IDX_W-1:0] idx);
        return vec[int'(idx) * LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/vec_lane_buffer.sv
// LANES x LANE_W capture register: clear on request, one indexed lane write per cycle.
module vec_lane_buffer #(
    parameter int unsigned LANES  = vec_pkg::LANES,
    parameter int unsigned LANE_W = vec_pkg::LANE_W,
    parameter int unsigned IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [LANE_W-1:0]       wr_data,
    output logic [LANES*LANE_W-1:0] vec
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (clr) begin
            vec <= '0;
        end else if (wr_en) begin
            vec[int'(wr_idx) * LANE_W +: LANE_W] <= wr_data;
        end
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// VLD/VST sequencer: moves a LANES x LANE_W vector through a LANE_W-wide memory, one lane per beat.
module vec_mem_sequencer
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [VEC_W-1:0]  store_data,
    output logic              busy,
    output logic              done,
    output logic [VEC_W-1:0]  load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0] mem_wdata,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state_q, state_nxt;
    logic [IDX_W-1:0]  cnt_q, cnt_nxt;
    logic              is_store_q;
    logic [ADDR_W-1:0] base_q;
    logic [VEC_W-1:0]  store_q;

    logic              start_acc_c;
    logic              beat_c;
    logic              st_sel_c;
    logic [ADDR_W-1:0] base_sel_c;
    logic [VEC_W-1:0]  vec_sel_c;
    logic              busy_nxt, done_nxt, req_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LANE_W-1:0] wdata_nxt;

    // Next state plus next-cycle outputs, so every memory-side output comes straight from a flop.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        start_acc_c = 1'b0;
        beat_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc_c = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    beat_c = 1'b1;
                    if (cnt_q == IDX_W'(LANES - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // The accepting edge must already drive beat 0, before the latches update.
        st_sel_c   = start_acc_c ? is_store   : is_store_q;
        base_sel_c = start_acc_c ? base_addr  : base_q;
        vec_sel_c  = start_acc_c ? store_data : store_q;

        busy_nxt  = (state_nxt != ST_IDLE);
        done_nxt  = (state_nxt == ST_DONE);
        req_nxt   = (state_nxt == ST_ACCESS);
        we_nxt    = req_nxt & st_sel_c;
        addr_nxt  = req_nxt ? ADDR_W'(base_sel_c + ADDR_W'(cnt_nxt)) : '0;
        wdata_nxt = we_nxt ? lane_slice(vec_sel_c, cnt_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            base_q     <= '0;
            store_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            if (start_acc_c) begin
                is_store_q <= is_store;
                base_q     <= base_addr;
                store_q    <= store_data;
            end
        end
    end

    // Load assembly; a store leaves the previous load vector untouched.
    vec_lane_buffer #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .IDX_W  (IDX_W)
    ) u_load_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc_c & ~is_store),
        .wr_en   (beat_c & ~is_store_q),
        .wr_idx  (cnt_q),
        .wr_data (mem_rdata),
        .vec     (load_data)
    );

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a behavioural 64K x 16 memory.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_store = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [255:0] store_data = '0;
    logic         busy, done, mem_req, mem_we;
    logic         mem_ready = 1'b0;
    logic [255:0] load_data;
    logic [15:0]  mem_addr, mem_wdata, mem_rdata;
    logic [15:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
    end

    vec_mem_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle start; returns positioned in cycle 1 of the transfer.
    task automatic issue(input logic st, input logic [15:0] base, input logic [255:0] vec);
        is_store   = st;
        base_addr  = base;
        store_data = vec;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        is_store   = 1'b0;
        base_addr  = 16'h0;
        store_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b req=%b we=%b expected all 0", busy, done, mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || load_data !== 256'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h load=%h expected 0", mem_addr, mem_wdata, load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vld();
        logic [255:0] exp;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + i] = 16'(16'hA000 + i);
            exp[i*16 +: 16]   = 16'(16'hA000 + i);
        end
        mem_ready = 1'b1;
        issue(1'b0, 16'h0100, '0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0 ||
                mem_addr !== 16'(16'h0100 + c - 1)) begin
                errors++;
                $display("FAIL vld_beat%0d req=%b we=%b busy=%b done=%b addr=%h expected 1 0 1 0 %h",
                         c, mem_req, mem_we, busy, done, mem_addr, 16'(16'h0100 + c - 1));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL vld_done_c17 done=%b busy=%b req=%b expected 1 1 0", done, busy, mem_req);
        end
        checks++;
        if (load_data !== exp) begin
            errors++;
            $display("FAIL vld_data got=%h expected=%h", load_data, exp);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL vld_idle_c18 done=%b busy=%b expected 0 0", done, busy);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_vst_stall(input logic [255:0] held_load);
        logic [255:0] vec;
        int idx;
        vec = '0;
        for (int i = 0; i < 16; i++) vec[i*16 +: 16] = 16'(32'h1111 * i);
        issue(1'b1, 16'h0200, vec);
        for (int c = 1; c <= 32; c++) begin
            idx = (c - 1) / 2;
            mem_ready = (c % 2 == 0);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'(16'h0200 + idx) ||
                mem_wdata !== 16'(32'h1111 * idx)) begin
                errors++;
                $display("FAIL vst_cycle%0d req=%b we=%b addr=%h wdata=%h expected 1 1 %h %h",
                         c, mem_req, mem_we, mem_addr, mem_wdata, 16'(16'h0200 + idx), 16'(32'h1111 * idx));
            end
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL vst_done_c33 done=%b busy=%b req=%b expected 1 1 0", done, busy, mem_req);
        end
        checks++;
        if (load_data !== held_load) begin
            errors++;
            $display("FAIL vst_load_held got=%h expected=%h", load_data, held_load);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[16'h0200 + i] !== 16'(32'h1111 * i)) begin
                errors++;
                $display("FAIL vst_mem%0d got=%h expected=%h", i, mem[16'h0200 + i], 16'(32'h1111 * i));
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [255:0] exp;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            mem[16'(16'hFFF8 + i)] = 16'(16'hB000 + i);
            exp[i*16 +: 16]        = 16'(16'hB000 + i);
        end
        mem_ready = 1'b1;
        issue(1'b0, 16'hFFF8, '0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'(16'hFFF8 + c - 1)) begin
                errors++;
                $display("FAIL wrap_beat%0d req=%b addr=%h expected 1 %h",
                         c, mem_req, mem_addr, 16'(16'hFFF8 + c - 1));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || load_data !== exp) begin
            errors++;
            $display("FAIL wrap_data done=%b got=%h expected done=1 %h", done, load_data, exp);
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_start_ignored();
        logic [255:0] exp;
        int dones;
        exp = '0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0500 + i] = 16'(16'hD000 + i);
            exp[i*16 +: 16]   = 16'(16'hD000 + i);
        end
        mem_ready = 1'b1;
        issue(1'b0, 16'h0500, '0);
        for (int c = 1; c <= 20; c++) begin
            if (c == 5 || c == 17) begin
                start = 1'b1; is_store = 1'b1; base_addr = 16'h0900; store_data = '1;
            end else begin
                start = 1'b0; is_store = 1'b0; base_addr = 16'h0; store_data = '0;
            end
            if (done === 1'b1) dones++;
            if (c <= 16) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== 16'(16'h0500 + c - 1)) begin
                    errors++;
                    $display("FAIL ign_beat%0d we=%b addr=%h expected 0 %h",
                             c, mem_we, mem_addr, 16'(16'h0500 + c - 1));
                end
            end
            if (c == 17) begin
                checks++;
                if (load_data !== exp) begin
                    errors++;
                    $display("FAIL ign_data got=%h expected=%h", load_data, exp);
                end
            end
            if (c >= 18) begin
                checks++;
                if (busy !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL ign_not_queued_c%0d busy=%b req=%b expected 0 0", c, busy, mem_req);
                end
            end
            tick();
        end
        start = 1'b0; is_store = 1'b0; base_addr = 16'h0; store_data = '0;
        mem_ready = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ign_done_count got=%0d expected=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] exp;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0600 + i] = 16'(16'hE000 + i);
            mem[16'h0700 + i] = 16'(16'hF000 + i);
            exp[i*16 +: 16]   = 16'(16'hF000 + i);
        end
        mem_ready = 1'b1;
        issue(1'b0, 16'h0600, '0);
        for (int c = 1; c <= 7; c++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || load_data !== 256'h0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid busy=%b req=%b done=%b addr=%h load=%h expected all 0",
                     busy, mem_req, done, mem_addr, load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(1'b0, 16'h0700, '0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'(16'h0700 + c - 1)) begin
                errors++;
                $display("FAIL rst_rerun_beat%0d req=%b addr=%h expected 1 %h",
                         c, mem_req, mem_addr, 16'(16'h0700 + c - 1));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || load_data !== exp) begin
            errors++;
            $display("FAIL rst_rerun_data done=%b got=%h expected done=1 %h", done, load_data, exp);
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [255:0] ld_exp, st_vec;
        ld_exp = '0;
        st_vec = '0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0300 + i]  = 16'(16'hC000 + i);
            ld_exp[i*16 +: 16] = 16'(16'hC000 + i);
            st_vec[i*16 +: 16] = 16'(16'h5A00 + i);
        end
        mem_ready = 1'b1;
        issue(1'b0, 16'h0300, '0);
        for (int c = 1; c <= 17; c++) tick();
        checks++;
        if (busy !== 1'b0 || load_data !== ld_exp) begin
            errors++;
            $display("FAIL b2b_load busy=%b got=%h expected busy=0 %h", busy, load_data, ld_exp);
        end
        issue(1'b1, 16'h0400, st_vec);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 16'(16'h0400 + c - 1) || mem_wdata !== 16'(16'h5A00 + c - 1)) begin
                errors++;
                $display("FAIL b2b_store_beat%0d we=%b addr=%h wdata=%h expected 1 %h %h", c, mem_we,
                         mem_addr, mem_wdata, 16'(16'h0400 + c - 1), 16'(16'h5A00 + c - 1));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || load_data !== ld_exp) begin
            errors++;
            $display("FAIL b2b_store_done done=%b load=%h expected done=1 %h", done, load_data, ld_exp);
        end
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [255:0] vld_vec;
        vld_vec = '0;
        for (int i = 0; i < 16; i++) vld_vec[i*16 +: 16] = 16'(16'hA000 + i);
        test_reset();
        test_vld();
        test_vst_stall(vld_vec);
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
